ps2_rx_fifo: RTL and testbench
==============================

// Module: ps2_rx_fifo
// PURPOSE
//  Parametrised PS/2 keyboard receiver with an integrated scan-code FIFO.
//  Synchronises ps2_clk/ps2_data into system_clk and decodes 11-bit frames.
//  Each frame is start 0, 8 data bits LSB first, odd parity, then stop 1.
//  Good bytes are queued in a DEPTH-entry first-word-fall-through FIFO read by the CPU peripheral bus.
//  Framing, parity and overflow errors are flagged rather than silently corrupting the queue.
// PARAMETERS
//  DEPTH          32     FIFO entries; power of two, >=2
//  ADDR_W         5      log2(DEPTH); pointer width
//  SYNC_STAGES    2      synchroniser flops on ps2_clk and ps2_data, >=2
//  TIMEOUT_CYCLES 50000  system_clk cycles without a PS/2 edge before a frame is abandoned
// PORTS
//  system_clk  in   1         system clock, all logic on rising edge
//  reset       in   1         asynchronous, active-high
//  ps2_clk     in   1         raw PS/2 clock (asynchronous)
//  ps2_data    in   1         raw PS/2 data (asynchronous)
//  read        in   1         pop head entry; ignored when empty
//  out         out  8         head of FIFO; 8'h00 when empty
//  empty       out  1         FIFO holds no entries
//  full        out  1         FIFO holds DEPTH entries
//  count       out  ADDR_W+1  entries held, 0..DEPTH
//  frame_err   out  1         1-cycle pulse: bad start, parity, stop or timeout
//  overflow    out  1         1-cycle pulse: good byte dropped because full
// BEHAVIOUR
//  Reset state:
//   - out=0, empty=1, full=0, count=0, frame_err=0, overflow=0.
//   - Pointers=0, FSM=IDLE, synchronisers load 1.
//  Edge detect:
//   - fall = synced ps2_clk was 1 last cycle and is 0 now.
//   - Data is sampled from synced ps2_data in the fall cycle.
//  FSM (advances only on fall):
//   - IDLE: data=0 -> DATA with bit index 0; data=1 -> stay IDLE, no error.
//   - DATA: shift in at bit[idx], LSB first; after bit 7 -> PARITY.
//   - PARITY: store bit -> STOP.
//   - STOP: always -> IDLE. Good frame = stop==1 and ^{data,parity}==1.
//  Frame result:
//   - Good and (!full or read this cycle) -> write mem[wr_ptr], wr_ptr++.
//   - Good and full and !read -> byte dropped, overflow=1 for one cycle.
//   - Bad -> nothing written, frame_err=1 for one cycle.
//  Latency: written byte is on out and empty=0 one cycle after the STOP fall cycle.
//  Read:
//   - read && !empty -> rd_ptr++ at next edge; out shows the next entry the same edge.
//   - read && empty -> no effect.
//  Simultaneous write and read:
//   - count unchanged; when full the write is accepted.
//   - When empty, the read is ignored and the write lands.
//  Arithmetic:
//   - Pointers are ADDR_W bits and wrap modulo DEPTH.
//   - count is ADDR_W+1 bits; full = (count==DEPTH).
//  Reset mid-frame: partial frame discarded, FIFO contents lost, no pulse.
// CONFIGURATION
//  PS2_RX_TIMEOUT_EN defined:
//   - A counter runs while FSM != IDLE and clears on every fall.
//   - When it reaches TIMEOUT_CYCLES, FSM -> IDLE and frame_err pulses once.
//  PS2_RX_TIMEOUT_EN undefined:
//   - No counter; the FSM waits indefinitely for edges.
//   - TIMEOUT_CYCLES is unused.
// TESTING
//  - Good frame, byte 8'h1C with parity 0 -> out=8'h1C, empty=0, count=1, no pulses.
//  - Byte 8'h1C with parity 1 -> frame_err pulses once, count stays 0.
//  - Frame with stop=0 -> frame_err pulses once, count stays 0.
//  - 33 good frames, no reads -> full=1 at 32, overflow pulses on the 33rd.
//    Then 32 reads return bytes in order and empty=1.
//  - Full FIFO, read asserted in the STOP fall cycle -> new byte accepted, count stays 32, no overflow.
//  - reset after 5 data bits, then a good 8'hF0 frame -> out=8'hF0, count=1.
//    With PS2_RX_TIMEOUT_EN, stalling 4 bits into a frame -> frame_err at TIMEOUT_CYCLES, then a good frame is accepted.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 keyboard receiver feeding a first-word-fall-through scan-code FIFO.
// Frames are 11 bits: start 0, 8 data bits LSB first, odd parity, stop 1.
// Optional feature macro: PS2_RX_TIMEOUT_EN abandons a stalled frame after
// TIMEOUT_CYCLES system_clk cycles without a PS/2 clock edge.
module ps2_rx_fifo #(
  parameter int DEPTH          = 32,
  parameter int ADDR_W         = 5,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic              system_clk,
  input  logic              reset,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  input  logic              read,
  output logic [7:0]        out,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              frame_err,
  output logic              overflow
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  // Synchroniser and edge detect
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_prev_q;
  logic                   clk_s;
  logic                   data_s;
  logic                   fall_s;

  // Frame decoder
  state_t                 state_q;
  logic [2:0]             bit_idx_q;
  logic [7:0]             shift_q;
  logic                   parity_q;
  logic                   frame_err_q;
  logic                   overflow_q;
  logic                   frame_done_s;
  logic                   frame_good_s;
  logic                   timeout_s;

  // FIFO
  logic [7:0]             mem_q [DEPTH];
  logic [ADDR_W-1:0]      wr_ptr_q;
  logic [ADDR_W-1:0]      wr_ptr_d;
  logic [ADDR_W-1:0]      rd_ptr_q;
  logic [ADDR_W-1:0]      rd_ptr_d;
  logic [ADDR_W:0]        count_q;
  logic [ADDR_W:0]        count_d;
  logic [7:0]             out_q;
  logic [7:0]             out_d;
  logic                   empty_q;
  logic                   full_q;
  logic                   wr_en_s;
  logic                   rd_en_s;

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign fall_s = clk_prev_q & ~clk_s;

  // Bring the raw PS/2 lines into system_clk and remember last synced clock level
  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q  <= clk_s;
    end
  end

  // The stop bit is sampled in the same cycle the frame result is decided
  assign frame_done_s = fall_s && (state_q == ST_STOP);
  assign frame_good_s = data_s && (^{shift_q, parity_q});
  // A full FIFO still accepts the byte when the CPU pops in the same cycle
  assign wr_en_s      = frame_done_s & frame_good_s & (~full_q | read);
  assign rd_en_s      = read & ~empty_q;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q;

  // Fires on the cycle the idle-edge counter would reach TIMEOUT_CYCLES
  assign timeout_s = (state_q != ST_IDLE) && !fall_s &&
                     (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Count cycles since the last PS/2 falling edge while a frame is in progress
  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      tmo_q <= '0;
    end else if ((state_q == ST_IDLE) || fall_s || timeout_s) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + TMO_W'(1);
    end
  end
`else
  logic [31:0] unused_timeout_s;

  assign timeout_s        = 1'b0;
  assign unused_timeout_s = 32'(TIMEOUT_CYCLES);
`endif

  // Frame decoder FSM with registered error/overflow pulses
  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      parity_q    <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      frame_err_q <= (frame_done_s & ~frame_good_s) | timeout_s;
      overflow_q  <= frame_done_s & frame_good_s & full_q & ~read;
      if (timeout_s) begin
        state_q <= ST_IDLE;
      end else if (fall_s) begin
        case (state_q)
          ST_IDLE: begin
            if (!data_s) begin
              state_q   <= ST_DATA;
              bit_idx_q <= 3'd0;
            end
          end
          ST_DATA: begin
            shift_q[bit_idx_q] <= data_s;
            if (bit_idx_q == 3'd7) begin
              state_q <= ST_PARITY;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
          ST_PARITY: begin
            parity_q <= data_s;
            state_q  <= ST_STOP;
          end
          ST_STOP: begin
            state_q <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Next pointers, occupancy and the head value that will be visible after this edge
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    out_d    = 8'h00;

    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (rd_en_s) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({wr_en_s, rd_en_s})
      2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
      default: count_d = count_q;
    endcase

    // The byte being written becomes the head when it is the only entry left
    if (count_d == '0) begin
      out_d = 8'h00;
    end else if (wr_en_s && (wr_ptr_q == rd_ptr_d)) begin
      out_d = shift_q;
    end else begin
      out_d = mem_q[rd_ptr_d];
    end
  end

  // FIFO storage; contents are meaningless until pointers say otherwise
  always_ff @(posedge system_clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  // FIFO pointers, occupancy and registered status outputs
  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      out_q    <= 8'h00;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      out_q    <= out_d;
      empty_q  <= (count_d == '0);
      full_q   <= (count_d == DEPTH_C);
    end
  end

  assign out       = out_q;
  assign empty     = empty_q;
  assign full      = full_q;
  assign count     = count_q;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: randomized PS/2 frame stimulus checked against a queue-based
// model of the receive FIFO (good/bad frames, overflow, reads, resets).
module tb_ps2_rx_fifo;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;
  localparam int SYNC   = 2;
  localparam int TMO    = 200;
  localparam int HALF   = 6;

  logic              system_clk = 1'b0;
  logic              reset      = 1'b1;
  logic              ps2_clk    = 1'b1;
  logic              ps2_data   = 1'b1;
  logic              read       = 1'b0;
  logic [7:0]        out;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              frame_err;
  logic              overflow;

  int n_checks = 0;
  int n_errors = 0;
  int fe_seen  = 0;
  int ov_seen  = 0;
  int fe_exp   = 0;
  int ov_exp   = 0;
  logic [7:0] model_q [$];

  always #5 system_clk = ~system_clk;

  ps2_rx_fifo #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .system_clk(system_clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .read(read), .out(out), .empty(empty), .full(full), .count(count),
    .frame_err(frame_err), .overflow(overflow)
  );

  // Count one-cycle pulses, sampled mid-cycle
  always @(negedge system_clk) begin
    if (frame_err === 1'b1) fe_seen++;
    if (overflow === 1'b1) ov_seen++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [7:0] head;
    head = (model_q.size() > 0) ? model_q[0] : 8'h00;
    check_eq({tag, "_count"}, 32'(count), 32'(model_q.size()));
    check_eq({tag, "_empty"}, 32'(empty), 32'(model_q.size() == 0));
    check_eq({tag, "_full"},  32'(full),  32'(model_q.size() == DEPTH));
    check_eq({tag, "_out"},   32'(out),   32'(head));
    check_eq({tag, "_ferr"},  32'(fe_seen), 32'(fe_exp));
    check_eq({tag, "_ovf"},   32'(ov_seen), 32'(ov_exp));
  endtask

  // One PS/2 bit; optionally pulse read in the cycle the falling edge is seen
  task automatic ps2_bit(input logic b, input bit rd_on_fall, output logic [7:0] out_at_read);
    out_at_read = 8'h00;
    @(negedge system_clk);
    ps2_data = b;
    repeat (HALF) @(negedge system_clk);
    ps2_clk = 1'b0;
    if (rd_on_fall) begin
      repeat (SYNC) @(posedge system_clk);
      #1;
      out_at_read = out;
      read = 1'b1;
      @(posedge system_clk);
      #1;
      read = 1'b0;
    end
    repeat (HALF) @(negedge system_clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input bit rd_stop, input string tag);
    logic       par;
    logic [7:0] seen;
    logic [7:0] head;
    bit         good;
    par = (~(^b)) ^ bad_par;
    ps2_bit(1'b0, 1'b0, seen);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0, seen);
    ps2_bit(par, 1'b0, seen);
    head = (model_q.size() > 0) ? model_q[0] : 8'h00;
    ps2_bit(~bad_stop, rd_stop, seen);
    good = !bad_par && !bad_stop;
    if (rd_stop) begin
      check_eq({tag, "_head_at_stop_read"}, 32'(seen), 32'(head));
      if (model_q.size() > 0) void'(model_q.pop_front());
    end
    if (good) begin
      if (model_q.size() < DEPTH) model_q.push_back(b);
      else ov_exp++;
    end else begin
      fe_exp++;
    end
    repeat (3) @(negedge system_clk);
    check_state(tag);
  endtask

  task automatic do_read(input string tag);
    logic [7:0] head;
    @(negedge system_clk);
    head = (model_q.size() > 0) ? model_q[0] : 8'h00;
    check_eq({tag, "_rd"}, 32'(out), 32'(head));
    read = 1'b1;
    @(negedge system_clk);
    read = 1'b0;
    if (model_q.size() > 0) void'(model_q.pop_front());
  endtask

  task automatic apply_reset();
    @(negedge system_clk);
    reset = 1'b1;
    read  = 1'b0;
    repeat (3) @(negedge system_clk);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    @(negedge system_clk);
    reset = 1'b0;
    model_q.delete();
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] dummy;
    int         kind;

    repeat (3) @(negedge system_clk);
    reset = 1'b0;
    @(negedge system_clk);
    check_state("reset");

    // Directed frames: good, bad parity, bad stop
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0, "good_1c");
    do_read("pop_1c");
    @(negedge system_clk);
    check_state("after_pop");
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0, "bad_parity");
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, "bad_stop");
    do_read("read_empty");
    @(negedge system_clk);
    check_state("read_empty_state");

    // Fill to DEPTH, then one more to overflow; drain in order
    for (int i = 0; i < DEPTH + 1; i++) begin
      v = 8'(i * 7 + 3);
      send_frame(v, 1'b0, 1'b0, 1'b0, "fill");
    end
    for (int i = 0; i < DEPTH; i++) do_read("drain");
    @(negedge system_clk);
    check_state("drained");

    // Full FIFO with a read in the STOP fall cycle accepts the new byte
    for (int i = 0; i < DEPTH; i++) begin
      v = 8'(8'hC0 ^ i);
      send_frame(v, 1'b0, 1'b0, 1'b0, "refill");
    end
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, "full_rd_at_stop");
    for (int i = 0; i < DEPTH; i++) do_read("drain2");
    @(negedge system_clk);
    check_state("drained2");

    // Reset after 5 data bits discards the partial frame and the FIFO
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, "pre_reset");
    ps2_bit(1'b0, 1'b0, dummy);
    for (int i = 0; i < 5; i++) ps2_bit(1'b1, 1'b0, dummy);
    apply_reset();
    @(negedge system_clk);
    check_state("mid_reset");
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0, "post_reset_f0");

`ifdef PS2_RX_TIMEOUT_EN
    // Stall 4 bits into a frame until the timeout abandons it
    ps2_bit(1'b0, 1'b0, dummy);
    for (int i = 0; i < 3; i++) ps2_bit(1'b1, 1'b0, dummy);
    repeat (TMO + 20) @(negedge system_clk);
    fe_exp++;
    check_state("timeout");
    send_frame(8'h3A, 1'b0, 1'b0, 1'b0, "after_timeout");
`endif

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      v    = 8'($urandom_range(0, 255));
      kind = $urandom_range(0, 7);
      send_frame(v, kind == 0, kind == 1, $urandom_range(0, 5) == 0, "rand");
      for (int r = 0; r < $urandom_range(0, 2); r++) do_read("rand");
    end
    @(negedge system_clk);
    check_state("final");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
